id_rename: RTL and testbench
============================

# id_rename

Parametrised rename/issue stage for the out-of-order core. It sits between the decoder/regfile read and the reservation stations. It keeps a register status table (busy bit plus producer tag per architectural register) and resolves each source operand to a value or a pending tag. It bypasses from CDB and ROB in the rename cycle, snoops the CDB while holding a result, and presents renamed operands through a one-entry valid/ready output register.

## Interface
- XLEN, 32, data width
- NREG, 32, architectural registers (x0 hardwired zero)
- TAG_W, 4, ROB tag width (2^TAG_W in-flight instructions)
- CDB_N, 2, number of common data bus broadcast ports
- OP_W, 10, opcode passthrough width

- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous squash of all speculative state
- in_valid / in_ready  in / out  1  decoded-instruction handshake
- in_op  in  OP_W  decoded operation
- in_rs1, in_rs2, in_rd  in  log2(NREG)  source/destination indices
- in_we  in  1  instruction writes in_rd
- in_imm1, in_imm2  in  XLEN  decoder constants used when a source index is 0
- in_rd1, in_rd2  in  XLEN  regfile read data for in_rs1/in_rs2
- alloc_valid  in  1  ROB has a free tag
- alloc_tag  in  TAG_W  tag to assign
- alloc_take  out  1  tag consumed this cycle
- rob_q1, rob_q2  out  TAG_W  table tags of in_rs1/in_rs2 for ROB lookup
- rob_rdy1, rob_rdy2  in  1  ROB entry holds a completed value
- rob_val1, rob_val2  in  XLEN  ROB entry value
- cdb_valid  in  CDB_N  broadcast valid per port
- cdb_tag  in  CDB_N*TAG_W  packed tags, port 0 in LSBs
- cdb_data  in  CDB_N*XLEN  packed data
- commit_valid, commit_rd, commit_tag  in  1/log2(NREG)/TAG_W  retirement
- out_valid / out_ready  out / in  1  issue handshake
- out_op  out  OP_W
- out_vj, out_vk  out  XLEN
- out_qj, out_qk  out  TAG_W
- out_rj, out_rk  out  1  operand ready
- out_tag, out_we, out_rd  out  TAG_W/1/log2(NREG)

## Operation
- Accept = in_valid & in_ready.
- in_ready = !flush & alloc_valid & (!out_valid | out_ready).
- alloc_take = Accept. Every accepted instruction takes a tag, x0 writers included.
- Source resolution, per source, using the table state before this cycle's update. First match wins:
  1. index 0: ready, value = in_imm.
  2. not busy: ready, value = in_rd.
  3. busy and a CDB port carries a matching tag: ready, value = cdb_data. If several ports match, the lowest port wins.
  4. busy and rob_rdy: ready, value = rob_val.
  5. otherwise: not ready, q = table tag, value = 0.
- Table update on Accept with in_we and in_rd != 0: busy = 1, tag = alloc_tag.
- Commit: clears busy[commit_rd] only if the stored tag equals commit_tag. Same cycle, same register rename wins; busy stays 1 with the new tag.
- Output register snoop: while out_valid and a source is not ready, a CDB tag match captures the data and sets ready.
  - The handshake transfers the pre-edge contents, so a reservation station must also snoop in the transfer cycle.
- Output register update: loaded on Accept. Otherwise cleared to invalid when out_ready. Holds under backpressure.
- flush: all busy bits cleared, out_valid cleared, no accept that cycle. Flush has priority over commit and accept.

## Timing
- Latency: 1 cycle from Accept to out_valid.
- Sustained throughput: 1/cycle with out_ready held high.
- Source lookup, rob_q outputs and in_ready are combinational. All outputs except in_ready, alloc_take and rob_q are registered.
- Reset values: busy = 0 and tags = 0 for all registers; out_valid = 0; every out_* = 0. Combinational outputs follow from these.
- Reset deasserted mid-stream: the first accept is possible in the first cycle after deassertion.
- out_* stay stable while out_valid & !out_ready, except rj/rk/vj/vk, which may only go not-ready to ready via snoop.

## Configuration
- ID_RENAME_PERF_EN defined: adds perf_renamed (32-bit, increments per Accept) and perf_stall (32-bit, increments when in_valid & !in_ready). Both counters wrap, and reset and flush do not affect each other's counting except that reset zeroes both.
- ID_RENAME_PERF_EN undefined: those ports and counters are absent. All other behaviour is identical.

## Test plan
- After reset, rename add x5 = x1 + x2 with alloc_tag 3 and in_rd1 = 7, in_rd2 = 9 -> next cycle out_vj = 7, out_vk = 9, rj = rk = 1, out_tag = 3, busy[5] = 1.
- Then rename with rs1 = 5 and no broadcast -> out_qj = 3, rj = 0. Next cycle cdb port 1 carries tag 3, data 0x55 -> out_rj = 1, out_vj = 0x55.
- Rename rs1 = 5 while cdb port 0 carries tag 3, data 0xAA in the same cycle -> out_rj = 1, out_vj = 0xAA. Repeat with rob_rdy1 = 1, rob_val1 = 0x11 and no CDB -> out_vj = 0x11.
- Commit x5 tag 3 while renaming rd = 5 with tag 6 in the same cycle -> busy[5] = 1, tag 6. A later commit of tag 3 for x5 leaves busy set.
- out_ready low for 3 cycles -> in_ready = 0 and out_* held. alloc_valid = 0 -> in_ready = 0 and alloc_take = 0.
- flush with out_valid = 1 and several busy registers -> next cycle out_valid = 0, all reads resolve from in_rd. Assert reset mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/id_rename_if.sv
// Bundle of every rename-stage signal except clock and reset.
// ID_RENAME_PERF_EN adds the perf_renamed / perf_stall counters.
interface id_rename_if #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int TAG_W = 4,
  parameter int CDB_N = 2,
  parameter int OP_W  = 10,
  parameter int RW    = $clog2(NREG)
);
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [OP_W-1:0]         in_op;
  logic [RW-1:0]           in_rs1;
  logic [RW-1:0]           in_rs2;
  logic [RW-1:0]           in_rd;
  logic                    in_we;
  logic [XLEN-1:0]         in_imm1;
  logic [XLEN-1:0]         in_imm2;
  logic [XLEN-1:0]         in_rd1;
  logic [XLEN-1:0]         in_rd2;
  logic                    alloc_valid;
  logic [TAG_W-1:0]        alloc_tag;
  logic                    alloc_take;
  logic [TAG_W-1:0]        rob_q1;
  logic [TAG_W-1:0]        rob_q2;
  logic                    rob_rdy1;
  logic                    rob_rdy2;
  logic [XLEN-1:0]         rob_val1;
  logic [XLEN-1:0]         rob_val2;
  logic [CDB_N-1:0]        cdb_valid;
  logic [CDB_N*TAG_W-1:0]  cdb_tag;
  logic [CDB_N*XLEN-1:0]   cdb_data;
  logic                    commit_valid;
  logic [RW-1:0]           commit_rd;
  logic [TAG_W-1:0]        commit_tag;
  logic                    out_valid;
  logic                    out_ready;
  logic [OP_W-1:0]         out_op;
  logic [XLEN-1:0]         out_vj;
  logic [XLEN-1:0]         out_vk;
  logic [TAG_W-1:0]        out_qj;
  logic [TAG_W-1:0]        out_qk;
  logic                    out_rj;
  logic                    out_rk;
  logic [TAG_W-1:0]        out_tag;
  logic                    out_we;
  logic [RW-1:0]           out_rd;
`ifdef ID_RENAME_PERF_EN
  logic [31:0]             perf_renamed;
  logic [31:0]             perf_stall;
`endif

  modport slave (
    input  flush, in_valid, in_op, in_rs1, in_rs2, in_rd, in_we, in_imm1, in_imm2,
           in_rd1, in_rd2, alloc_valid, alloc_tag, rob_rdy1, rob_rdy2, rob_val1,
           rob_val2, cdb_valid, cdb_tag, cdb_data, commit_valid, commit_rd,
           commit_tag, out_ready,
    output in_ready, alloc_take, rob_q1, rob_q2, out_valid, out_op, out_vj, out_vk,
           out_qj, out_qk, out_rj, out_rk, out_tag, out_we, out_rd
`ifdef ID_RENAME_PERF_EN
           , perf_renamed, perf_stall
`endif
  );

  modport master (
    output flush, in_valid, in_op, in_rs1, in_rs2, in_rd, in_we, in_imm1, in_imm2,
           in_rd1, in_rd2, alloc_valid, alloc_tag, rob_rdy1, rob_rdy2, rob_val1,
           rob_val2, cdb_valid, cdb_tag, cdb_data, commit_valid, commit_rd,
           commit_tag, out_ready,
    input  in_ready, alloc_take, rob_q1, rob_q2, out_valid, out_op, out_vj, out_vk,
           out_qj, out_qk, out_rj, out_rk, out_tag, out_we, out_rd
`ifdef ID_RENAME_PERF_EN
           , perf_renamed, perf_stall
`endif
  );
endinterface

// File: rtl/id_rename.sv
// Rename/issue stage: register status table, CDB/ROB operand bypass, one-entry output register.
// ID_RENAME_PERF_EN adds wrapping accept and stall counters.
module id_rename #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int TAG_W = 4,
  parameter int CDB_N = 2,
  parameter int OP_W  = 10
) (
  input logic       clk,
  input logic       reset,
  id_rename_if.slave bus
);
  localparam int RW = $clog2(NREG);

  typedef struct packed {
    logic             rdy;
    logic [TAG_W-1:0] q;
    logic [XLEN-1:0]  v;
  } src_t;

  typedef struct packed {
    logic            hit;
    logic [XLEN-1:0] data;
  } snoop_t;

  logic [NREG-1:0]  busy;
  logic [TAG_W-1:0] tag_tab [NREG];
  logic             accept;

  logic [CDB_N-1:0] cdb_v;
  logic [TAG_W-1:0] cdb_t [CDB_N];
  logic [XLEN-1:0]  cdb_d [CDB_N];

  src_t   src1, src2;
  snoop_t snoop_j, snoop_k;

  always_comb begin
    cdb_v = bus.cdb_valid;
    for (int p = 0; p < CDB_N; p++) begin
      cdb_t[p] = bus.cdb_tag[p*TAG_W +: TAG_W];
      cdb_d[p] = bus.cdb_data[p*XLEN +: XLEN];
    end
  end

  // Scans from the top port down so the lowest matching port is the last write.
  function automatic snoop_t cdb_match(input logic [TAG_W-1:0] t);
    cdb_match = '0;
    for (int p = CDB_N - 1; p >= 0; p--) begin
      if (cdb_v[p] && cdb_t[p] == t) begin
        cdb_match.hit  = 1'b1;
        cdb_match.data = cdb_d[p];
      end
    end
  endfunction

  function automatic src_t resolve(input logic [RW-1:0]   idx,
                                   input logic [XLEN-1:0] imm,
                                   input logic [XLEN-1:0] rf,
                                   input logic            rob_rdy,
                                   input logic [XLEN-1:0] rob_val);
    snoop_t s;
    resolve = '0;
    s = cdb_match(tag_tab[idx]);
    if (idx == '0) begin
      resolve.rdy = 1'b1;
      resolve.v   = imm;
    end else if (!busy[idx]) begin
      resolve.rdy = 1'b1;
      resolve.v   = rf;
    end else if (s.hit) begin
      resolve.rdy = 1'b1;
      resolve.v   = s.data;
    end else if (rob_rdy) begin
      resolve.rdy = 1'b1;
      resolve.v   = rob_val;
    end else begin
      resolve.q   = tag_tab[idx];
    end
  endfunction

  assign bus.in_ready   = !bus.flush && bus.alloc_valid && (!bus.out_valid || bus.out_ready);
  assign accept         = bus.in_valid && bus.in_ready;
  assign bus.alloc_take = accept;
  assign bus.rob_q1     = tag_tab[bus.in_rs1];
  assign bus.rob_q2     = tag_tab[bus.in_rs2];

  // NOTE: each always_comb result comes from a function that assigns '0 first, so no path leaves a latch.
  always_comb begin
    src1    = resolve(bus.in_rs1, bus.in_imm1, bus.in_rd1, bus.rob_rdy1, bus.rob_val1);
    src2    = resolve(bus.in_rs2, bus.in_imm2, bus.in_rd2, bus.rob_rdy2, bus.rob_val2);
    snoop_j = cdb_match(bus.out_qj);
    snoop_k = cdb_match(bus.out_qk);
  end

  // NOTE: the tag table is a memory but is reset anyway, because the rob_q outputs must read 0 out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
      for (int r = 0; r < NREG; r++) tag_tab[r] <= '0;
    end else if (bus.flush) begin
      busy <= '0;
    end else begin
      if (bus.commit_valid && tag_tab[bus.commit_rd] == bus.commit_tag)
        busy[bus.commit_rd] <= 1'b0;
      // NOTE: non-blocking, so this later write overrides a same-register commit clear above.
      if (accept && bus.in_we && bus.in_rd != '0) begin
        busy[bus.in_rd]    <= 1'b1;
        tag_tab[bus.in_rd] <= bus.alloc_tag;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.out_op    <= '0;
      bus.out_vj    <= '0;
      bus.out_vk    <= '0;
      bus.out_qj    <= '0;
      bus.out_qk    <= '0;
      bus.out_rj    <= 1'b0;
      bus.out_rk    <= 1'b0;
      bus.out_tag   <= '0;
      bus.out_we    <= 1'b0;
      bus.out_rd    <= '0;
    end else if (bus.flush) begin
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.out_op    <= bus.in_op;
      bus.out_vj    <= src1.v;
      bus.out_vk    <= src2.v;
      bus.out_qj    <= src1.q;
      bus.out_qk    <= src2.q;
      bus.out_rj    <= src1.rdy;
      bus.out_rk    <= src2.rdy;
      bus.out_tag   <= bus.alloc_tag;
      bus.out_we    <= bus.in_we;
      bus.out_rd    <= bus.in_rd;
    end else begin
      if (bus.out_ready) bus.out_valid <= 1'b0;
      if (bus.out_valid && !bus.out_rj && snoop_j.hit) begin
        bus.out_rj <= 1'b1;
        bus.out_vj <= snoop_j.data;
      end
      if (bus.out_valid && !bus.out_rk && snoop_k.hit) begin
        bus.out_rk <= 1'b1;
        bus.out_vk <= snoop_k.data;
      end
    end
  end

`ifdef ID_RENAME_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.perf_renamed <= '0;
      bus.perf_stall   <= '0;
    end else begin
      if (accept) bus.perf_renamed <= bus.perf_renamed + 32'd1;
      if (bus.in_valid && !bus.in_ready) bus.perf_stall <= bus.perf_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_id_rename.sv
// Directed self-checking bench for id_rename: reset, bypass, snoop, commit race, backpressure, flush.
module tb_id_rename;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  id_rename_if #(.XLEN(32), .NREG(32), .TAG_W(4), .CDB_N(2), .OP_W(10)) bus ();

  id_rename #(.XLEN(32), .NREG(32), .TAG_W(4), .CDB_N(2), .OP_W(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush = 0; bus.in_valid = 0; bus.in_op = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
    bus.in_rd = '0; bus.in_we = 0; bus.in_imm1 = '0; bus.in_imm2 = '0; bus.in_rd1 = '0;
    bus.in_rd2 = '0; bus.alloc_valid = 1; bus.alloc_tag = '0; bus.rob_rdy1 = 0;
    bus.rob_rdy2 = 0; bus.rob_val1 = '0; bus.rob_val2 = '0; bus.cdb_valid = '0;
    bus.cdb_tag = '0; bus.cdb_data = '0; bus.commit_valid = 0; bus.commit_rd = '0;
    bus.commit_tag = '0; bus.out_ready = 1;
  endtask

  task automatic issue(input logic [9:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic we, input logic [31:0] rd1,
                       input logic [31:0] rd2, input logic [3:0] tag);
    bus.in_valid = 1; bus.in_op = op; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_rd = rd;
    bus.in_we = we; bus.in_rd1 = rd1; bus.in_rd2 = rd2; bus.alloc_tag = tag;
  endtask

  task automatic test_reset();
    idle();
    bus.in_rs1 = 5'd5;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0d want 0", bus.out_valid); end
    checks++; if (bus.out_tag !== 4'd0) begin errors++; $display("FAIL reset_out_tag got %0d want 0", bus.out_tag); end
    checks++; if (bus.out_vj !== 32'd0) begin errors++; $display("FAIL reset_out_vj got %0h want 0", bus.out_vj); end
    checks++; if (bus.rob_q1 !== 4'd0) begin errors++; $display("FAIL reset_rob_q1 got %0d want 0", bus.rob_q1); end
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic test_basic_and_snoop();
    idle();
    issue(10'h21, 5'd1, 5'd2, 5'd5, 1, 32'd7, 32'd9, 4'd3);
    #1;
    checks++; if (bus.alloc_take !== 1'b1) begin errors++; $display("FAIL basic_alloc_take got %0d want 1", bus.alloc_take); end
    tick();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got %0d want 1", bus.out_valid); end
    checks++; if (bus.out_vj !== 32'd7) begin errors++; $display("FAIL basic_vj got %0h want 7", bus.out_vj); end
    checks++; if (bus.out_vk !== 32'd9) begin errors++; $display("FAIL basic_vk got %0h want 9", bus.out_vk); end
    checks++; if ({bus.out_rj, bus.out_rk} !== 2'b11) begin errors++; $display("FAIL basic_rjrk got %b want 11", {bus.out_rj, bus.out_rk}); end
    checks++; if (bus.out_tag !== 4'd3) begin errors++; $display("FAIL basic_tag got %0d want 3", bus.out_tag); end
    checks++; if ({bus.out_op, bus.out_we, bus.out_rd} !== {10'h21, 1'b1, 5'd5}) begin errors++; $display("FAIL basic_op_we_rd got %0h want %0h", {bus.out_op, bus.out_we, bus.out_rd}, {10'h21, 1'b1, 5'd5}); end
    issue(10'h22, 5'd5, 5'd0, 5'd6, 0, 32'hdead, 32'd0, 4'd4);
    bus.in_imm2 = 32'h123;
    #1;
    checks++; if (bus.rob_q1 !== 4'd3) begin errors++; $display("FAIL pend_rob_q1 got %0d want 3", bus.rob_q1); end
    tick();
    checks++; if ({bus.out_rj, bus.out_qj} !== {1'b0, 4'd3}) begin errors++; $display("FAIL pend_rj_qj got %0h want 3", {bus.out_rj, bus.out_qj}); end
    checks++; if (bus.out_vj !== 32'd0) begin errors++; $display("FAIL pend_vj got %0h want 0", bus.out_vj); end
    checks++; if ({bus.out_rk, bus.out_vk} !== {1'b1, 32'h123}) begin errors++; $display("FAIL pend_imm2 got %0h want 100000123", {bus.out_rk, bus.out_vk}); end
    idle();
    bus.out_ready = 0;
    bus.cdb_valid = 2'b10; bus.cdb_tag = {4'd3, 4'd0}; bus.cdb_data = {32'h55, 32'h0};
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL snoop_in_ready got %0d want 0", bus.in_ready); end
    tick();
    checks++; if ({bus.out_valid, bus.out_rj} !== 2'b11) begin errors++; $display("FAIL snoop_valid_rj got %b want 11", {bus.out_valid, bus.out_rj}); end
    checks++; if (bus.out_vj !== 32'h55) begin errors++; $display("FAIL snoop_vj got %0h want 55", bus.out_vj); end
    checks++; if ({bus.out_qj, bus.out_tag} !== {4'd3, 4'd4}) begin errors++; $display("FAIL snoop_held got %0h want 34", {bus.out_qj, bus.out_tag}); end
    idle();
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %0d want 0", bus.out_valid); end
  endtask

  task automatic test_bypass();
    idle();
    issue(10'h30, 5'd5, 5'd0, 5'd0, 0, 32'd0, 32'd0, 4'd5);
    bus.cdb_valid = 2'b11; bus.cdb_tag = {4'd3, 4'd3}; bus.cdb_data = {32'hBB, 32'hAA};
    tick();
    checks++; if ({bus.out_rj, bus.out_vj} !== {1'b1, 32'hAA}) begin errors++; $display("FAIL cdb_bypass got %0h want 1000000aa", {bus.out_rj, bus.out_vj}); end
    idle();
    issue(10'h31, 5'd5, 5'd0, 5'd0, 0, 32'd0, 32'd0, 4'd6);
    bus.rob_rdy1 = 1; bus.rob_val1 = 32'h11;
    tick();
    checks++; if ({bus.out_rj, bus.out_vj} !== {1'b1, 32'h11}) begin errors++; $display("FAIL rob_bypass got %0h want 100000011", {bus.out_rj, bus.out_vj}); end
    idle();
    issue(10'h32, 5'd5, 5'd0, 5'd0, 0, 32'd0, 32'd0, 4'd7);
    bus.cdb_valid = 2'b01; bus.cdb_tag = {4'd0, 4'd2}; bus.cdb_data = {32'h0, 32'hEE};
    tick();
    checks++; if ({bus.out_rj, bus.out_qj} !== {1'b0, 4'd3}) begin errors++; $display("FAIL cdb_miss got %0h want 3", {bus.out_rj, bus.out_qj}); end
  endtask

  task automatic test_commit();
    idle();
    issue(10'h40, 5'd0, 5'd0, 5'd5, 1, 32'd0, 32'd0, 4'd6);
    bus.commit_valid = 1; bus.commit_rd = 5'd5; bus.commit_tag = 4'd3;
    tick();
    idle();
    bus.in_rs1 = 5'd5;
    bus.commit_valid = 1; bus.commit_rd = 5'd5; bus.commit_tag = 4'd3;
    #1;
    checks++; if (bus.rob_q1 !== 4'd6) begin errors++; $display("FAIL commit_race_tag got %0d want 6", bus.rob_q1); end
    tick();
    idle();
    issue(10'h41, 5'd5, 5'd0, 5'd0, 0, 32'h77, 32'd0, 4'd7);
    tick();
    checks++; if ({bus.out_rj, bus.out_qj} !== {1'b0, 4'd6}) begin errors++; $display("FAIL stale_commit got %0h want 6", {bus.out_rj, bus.out_qj}); end
    idle();
    bus.commit_valid = 1; bus.commit_rd = 5'd5; bus.commit_tag = 4'd6;
    tick();
    idle();
    issue(10'h42, 5'd5, 5'd0, 5'd0, 0, 32'h77, 32'd0, 4'd8);
    tick();
    checks++; if ({bus.out_rj, bus.out_vj} !== {1'b1, 32'h77}) begin errors++; $display("FAIL commit_clear got %0h want 100000077", {bus.out_rj, bus.out_vj}); end
  endtask

  task automatic test_backpressure();
    idle();
    issue(10'h50, 5'd1, 5'd2, 5'd0, 0, 32'h100, 32'h200, 4'd9);
    tick();
    bus.out_ready = 0;
    issue(10'h51, 5'd3, 5'd4, 5'd0, 0, 32'h300, 32'h400, 4'd10);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if ({bus.in_ready, bus.alloc_take} !== 2'b00) begin errors++; $display("FAIL bp_in_ready[%0d] got %b want 00", i, {bus.in_ready, bus.alloc_take}); end
      tick();
      checks++; if ({bus.out_valid, bus.out_tag, bus.out_op, bus.out_vj} !== {1'b1, 4'd9, 10'h50, 32'h100}) begin errors++; $display("FAIL bp_hold[%0d] tag %0d op %0h vj %0h want 9 50 100", i, bus.out_tag, bus.out_op, bus.out_vj); end
    end
    bus.out_ready = 1;
    tick();
    checks++; if ({bus.out_tag, bus.out_op, bus.out_vj} !== {4'd10, 10'h51, 32'h300}) begin errors++; $display("FAIL bp_release tag %0d op %0h vj %0h want 10 51 300", bus.out_tag, bus.out_op, bus.out_vj); end
    idle();
    bus.alloc_valid = 0;
    bus.in_valid = 1;
    #1;
    checks++; if ({bus.in_ready, bus.alloc_take} !== 2'b00) begin errors++; $display("FAIL no_alloc got %b want 00", {bus.in_ready, bus.alloc_take}); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL no_alloc_valid got %0d want 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    idle();
    issue(10'h60, 5'd0, 5'd0, 5'd7, 1, 32'd0, 32'd0, 4'd8);
    tick();
    issue(10'h61, 5'd0, 5'd0, 5'd8, 1, 32'd0, 32'd0, 4'd9);
    tick();
    bus.out_ready = 0;
    issue(10'h62, 5'd7, 5'd0, 5'd9, 1, 32'd0, 32'd0, 4'd11);
    bus.flush = 1;
    #1;
    checks++; if ({bus.in_ready, bus.alloc_take} !== 2'b00) begin errors++; $display("FAIL flush_accept got %b want 00", {bus.in_ready, bus.alloc_take}); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0d want 0", bus.out_valid); end
    idle();
    issue(10'h63, 5'd7, 5'd8, 5'd0, 0, 32'h1, 32'h2, 4'd10);
    tick();
    checks++; if ({bus.out_rj, bus.out_vj, bus.out_rk, bus.out_vk} !== {1'b1, 32'h1, 1'b1, 32'h2}) begin errors++; $display("FAIL flush_clear rj %0d vj %0h rk %0d vk %0h want 1 1 1 2", bus.out_rj, bus.out_vj, bus.out_rk, bus.out_vk); end
  endtask

  task automatic test_back_to_back();
    idle();
    for (int i = 0; i < 4; i++) begin
      issue(10'h70 + 10'(i), 5'd0, 5'd0, 5'd0, 0, 32'd0, 32'd0, 4'(12 + i));
      tick();
      checks++; if ({bus.out_valid, bus.out_tag, bus.out_op} !== {1'b1, 4'(12 + i), 10'h70 + 10'(i)}) begin errors++; $display("FAIL b2b[%0d] valid %0d tag %0d op %0h", i, bus.out_valid, bus.out_tag, bus.out_op); end
    end
  endtask

  task automatic test_reset_mid();
    idle();
    issue(10'h80, 5'd0, 5'd0, 5'd9, 1, 32'd0, 32'd0, 4'd13);
    tick();
    issue(10'h81, 5'd9, 5'd0, 5'd0, 0, 32'd0, 32'd0, 4'd14);
    #2 reset = 1;
    #1;
    checks++; if ({bus.out_valid, bus.out_tag, bus.out_op, bus.out_we, bus.out_rd} !== '0) begin errors++; $display("FAIL mid_reset_out valid %0d tag %0d op %0h", bus.out_valid, bus.out_tag, bus.out_op); end
    checks++; if (bus.rob_q1 !== 4'd0) begin errors++; $display("FAIL mid_reset_table got %0d want 0", bus.rob_q1); end
    @(posedge clk);
    #1 reset = 0;
    issue(10'h82, 5'd9, 5'd0, 5'd0, 0, 32'h99, 32'd0, 4'd15);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %0d want 1", bus.in_ready); end
    @(posedge clk);
    #1;
    checks++; if ({bus.out_valid, bus.out_rj, bus.out_vj, bus.out_tag} !== {1'b1, 1'b1, 32'h99, 4'd15}) begin errors++; $display("FAIL post_reset_first valid %0d rj %0d vj %0h tag %0d", bus.out_valid, bus.out_rj, bus.out_vj, bus.out_tag); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_and_snoop();
    test_bypass();
    test_commit();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    idle();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
